// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port block RAM wrapper.
package mem_pkg;

  localparam int XLEN           = 32;
  localparam int MEM_SIZE_BYTES = 4096;

  // Widest word the byte-merge helper handles.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_e;

  // Number of address bits that select a byte within a word.
  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Replace each byte of old_w with the byte of new_w whose strobe is set.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read response pipeline: READ_LAT register stages carrying valid, err and data.
// Data stages only load on a valid read so rdata holds its last value between responses.
module bram_rd_pipe #(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  logic [READ_LAT-1:0] valid_q, valid_d;
  logic [READ_LAT-1:0] err_q, err_d;
  logic [DATA_W-1:0]   data_q [READ_LAT];
  logic [DATA_W-1:0]   data_d [READ_LAT];

  // Shift valid/err every cycle; advance data only behind a valid response.
  always_comb begin
    valid_d   = '0;
    err_d     = '0;
    data_d    = data_q;
    valid_d[0] = in_valid;
    err_d[0]   = in_err;
    data_d[0]  = in_valid ? in_data : data_q[0];
    for (int i = 1; i < READ_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  // Stage registers; reset flushes any response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < READ_LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < READ_LAT; i++) data_q[i] <= data_d[i];
    end
  end

  // Last stage drives the port.
  always_comb begin
    out_valid = valid_q[READ_LAT-1];
    out_err   = err_q[READ_LAT-1];
    out_data  = data_q[READ_LAT-1];
  end

endmodule

// File: rtl/dualport_bram_pipe.sv
// True dual-port word memory with byte strobes, pipelined reads and a post-reset clear sweep.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | sweep writes zero to word clr_cnt_q each cycle, ports held off
//   RUN   | both ports accept every request, one per cycle each
module dualport_bram_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = MEM_SIZE_BYTES / (DATA_W / 8),
  parameter int READ_LAT       = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_mem_req,
  input  logic                a_mem_we,
  input  logic [XLEN-1:0]     a_mem_addr,
  input  logic [DATA_W-1:0]   a_mem_wdata,
  input  logic [DATA_W/8-1:0] a_mem_wstrb,
  output logic                a_mem_ready,
  output logic                a_mem_rvalid,
  output logic [DATA_W-1:0]   a_mem_rdata,
  output logic                a_mem_err,
  input  logic                b_mem_req,
  input  logic                b_mem_we,
  input  logic [XLEN-1:0]     b_mem_addr,
  input  logic [DATA_W-1:0]   b_mem_wdata,
  input  logic [DATA_W/8-1:0] b_mem_wstrb,
  output logic                b_mem_ready,
  output logic                b_mem_rvalid,
  output logic [DATA_W-1:0]   b_mem_rdata,
  output logic                b_mem_err,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = byte_off_w(DATA_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam mem_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    return DATA_W'(strb_merge(MAX_DATA_W'(old_w), MAX_DATA_W'(new_w), MAX_STRB_W'(strb)));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_e        state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              run, clr_we;

  logic [XLEN-1:0]   a_widx, b_widx;
  logic [IDX_W-1:0]  a_i, b_i;
  logic              a_in, b_in;
  logic              a_acc, b_acc, a_wr, b_wr, wr_same;
  logic [DATA_W-1:0] a_word, b_word, a_wword, b_wword, a_rword, b_rword;

  // State register and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: walk every index once, then hand the array to the ports.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM outputs; nothing is accepted or swept while reset is held.
  always_comb begin
    busy        = (state_q == CLEAR);
    run         = rst_n && (state_q == RUN);
    clr_we      = rst_n && (state_q == CLEAR);
    a_mem_ready = run && a_mem_req;
    b_mem_ready = run && b_mem_req;
  end

  // Address decode, write merging and read-data selection for both ports.
  always_comb begin
    a_widx  = a_mem_addr >> OFF_W;
    b_widx  = b_mem_addr >> OFF_W;
    a_in    = a_widx < XLEN'(DEPTH);
    b_in    = b_widx < XLEN'(DEPTH);
    a_i     = a_widx[IDX_W-1:0];
    b_i     = b_widx[IDX_W-1:0];
    a_word  = mem[a_i];
    b_word  = mem[b_i];
    a_acc   = run && a_mem_req;
    b_acc   = run && b_mem_req;
    a_wr    = a_acc && a_mem_we && a_in;
    b_wr    = b_acc && b_mem_we && b_in;
    wr_same = a_wr && b_wr && (a_i == b_i);
    // Same-index dual write: port B's strobes are layered over port A's merged word.
    a_wword = merge(a_word, a_mem_wdata, a_mem_wstrb);
    b_wword = merge(wr_same ? a_wword : b_word, b_mem_wdata, b_mem_wstrb);
    a_rword = '0;
    if (a_in) begin
      a_rword = a_word;
      if ((WRITE_FIRST != 0) && b_wr && (b_i == a_i)) a_rword = b_wword;
    end
    b_rword = '0;
    if (b_in) begin
      b_rword = b_word;
      if ((WRITE_FIRST != 0) && a_wr && (a_i == b_i)) b_rword = a_wword;
    end
  end

  // Storage array: sweep has priority, and a same-index pair commits only port B's merged word.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (a_wr && !wr_same) mem[a_i] <= a_wword;
      if (b_wr)             mem[b_i] <= b_wword;
    end
  end

  bram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_a_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (a_acc && !a_mem_we),
    .in_err   (a_acc && !a_in),
    .in_data  (a_rword),
    .out_valid(a_mem_rvalid),
    .out_err  (a_mem_err),
    .out_data (a_mem_rdata)
  );

  bram_rd_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_b_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (b_acc && !b_mem_we),
    .in_err   (b_acc && !b_in),
    .in_data  (b_rword),
    .out_valid(b_mem_rvalid),
    .out_err  (b_mem_err),
    .out_data (b_mem_rdata)
  );

endmodule

// File: tb/tb_dualport_bram_pipe.sv
// Directed bench: dut1 is read-first with 1-cycle latency, dut2 is write-first with
// 2-cycle latency; both share one stimulus stream and a 16-word array.
module tb_dualport_bram_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_wstrb, b_wstrb;

  logic        a_ready_1, a_rvalid_1, a_err_1, b_ready_1, b_rvalid_1, b_err_1, busy_1;
  logic        a_ready_2, a_rvalid_2, a_err_2, b_ready_2, b_rvalid_2, b_err_2, busy_2;
  logic [31:0] a_rdata_1, b_rdata_1, a_rdata_2, b_rdata_2;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  dualport_bram_pipe #(.DATA_W(32), .DEPTH(16), .READ_LAT(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_mem_req(a_req), .a_mem_we(a_we), .a_mem_addr(a_addr), .a_mem_wdata(a_wdata), .a_mem_wstrb(a_wstrb),
    .a_mem_ready(a_ready_1), .a_mem_rvalid(a_rvalid_1), .a_mem_rdata(a_rdata_1), .a_mem_err(a_err_1),
    .b_mem_req(b_req), .b_mem_we(b_we), .b_mem_addr(b_addr), .b_mem_wdata(b_wdata), .b_mem_wstrb(b_wstrb),
    .b_mem_ready(b_ready_1), .b_mem_rvalid(b_rvalid_1), .b_mem_rdata(b_rdata_1), .b_mem_err(b_err_1),
    .busy(busy_1)
  );

  dualport_bram_pipe #(.DATA_W(32), .DEPTH(16), .READ_LAT(2), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_mem_req(a_req), .a_mem_we(a_we), .a_mem_addr(a_addr), .a_mem_wdata(a_wdata), .a_mem_wstrb(a_wstrb),
    .a_mem_ready(a_ready_2), .a_mem_rvalid(a_rvalid_2), .a_mem_rdata(a_rdata_2), .a_mem_err(a_err_2),
    .b_mem_req(b_req), .b_mem_we(b_we), .b_mem_addr(b_addr), .b_mem_wdata(b_wdata), .b_mem_wstrb(b_wstrb),
    .b_mem_ready(b_ready_2), .b_mem_rvalid(b_rvalid_2), .b_mem_rdata(b_rdata_2), .b_mem_err(b_err_2),
    .busy(busy_2)
  );

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_wstrb = strb;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_wstrb = strb;
  endtask

  function automatic logic [31:0] expw(input int i);
    return (i < 4) ? (32'hA000_0000 | 32'(i)) : (32'hB000_0000 | 32'(i));
  endfunction

  // Count busy cycles from reset release; bounded so a stuck sweep still ends.
  task automatic wait_clear(input string tag);
    int   n = 0;
    logic rdy_seen = 1'b0;
    while ((busy_1 === 1'b1) && (n < 40)) begin
      if ((a_ready_1 !== 1'b0) || (a_ready_2 !== 1'b0)) rdy_seen = 1'b1;
      n++;
      tick();
    end
    chkw({tag, " busy cycles"}, n, 32'd16);
    chk1({tag, " ready during clear"}, rdy_seen, 1'b0);
    chk1({tag, " busy2 done"}, busy_2, 1'b0);
  endtask

  initial begin
    logic seen;
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset values
    chk1("rst a_ready", a_ready_1, 1'b0);
    chk1("rst a_rvalid", a_rvalid_1, 1'b0);
    chk1("rst a_err", a_err_1, 1'b0);
    chkw("rst a_rdata", a_rdata_1, 32'h0);
    chk1("rst busy1", busy_1, 1'b1);
    chk1("rst busy2", busy_2, 1'b1);
    chk1("rst b_rvalid2", b_rvalid_2, 1'b0);
    chkw("rst a_rdata2", a_rdata_2, 32'h0);

    // Read of index 5 held through the sweep, accepted on the first RUN cycle
    set_a(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    rst_n = 1'b1;
    wait_clear("clr1");
    #1;
    chk1("first ready a1", a_ready_1, 1'b1);
    chk1("first ready a2", a_ready_2, 1'b1);
    chk1("idle ready b1", b_ready_1, 1'b0);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk1("rd5 rvalid1", a_rvalid_1, 1'b1);
    chkw("rd5 rdata1", a_rdata_1, 32'h0);
    chk1("rd5 rvalid2 early", a_rvalid_2, 1'b0);
    tick();
    chk1("rd5 rvalid1 gone", a_rvalid_1, 1'b0);
    chk1("rd5 rvalid2", a_rvalid_2, 1'b1);
    chkw("rd5 rdata2", a_rdata_2, 32'h0);
    chk1("rd5 err2", a_err_2, 1'b0);

    // Byte strobes
    set_a(1'b1, 1'b1, 32'h10, 32'h1122_3344, 4'hF);
    tick();
    set_a(1'b1, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
    tick();
    chk1("write no rvalid", a_rvalid_1, 1'b0);
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk1("strb rvalid1", b_rvalid_1, 1'b1);
    chkw("strb rdata1", b_rdata_1, 32'h11BB_33DD);
    tick();
    chk1("strb rvalid2", b_rvalid_2, 1'b1);
    chkw("strb rdata2", b_rdata_2, 32'h11BB_33DD);

    // Same-index dual write merge
    set_a(1'b1, 1'b1, 32'h0C, 32'h0000_FFFF, 4'hF);
    set_b(1'b1, 1'b1, 32'h0C, 32'hAAAA_0000, 4'b1100);
    tick();
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_a(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk1("merge rvalid1", a_rvalid_1, 1'b1);
    chkw("merge rdata1", a_rdata_1, 32'hAAAA_FFFF);
    tick();
    chkw("merge rdata2", a_rdata_2, 32'hAAAA_FFFF);

    // Read/write collision on index 7: old data (dut1) vs new data (dut2)
    set_a(1'b1, 1'b1, 32'h1C, 32'h1234_5678, 4'hF);
    set_b(1'b1, 1'b0, 32'h1C, 32'h0, 4'h0);
    tick();
    set_a(1'b1, 1'b0, 32'h1C, 32'h0, 4'h0);
    chk1("coll rvalid1", b_rvalid_1, 1'b1);
    chkw("coll read-first", b_rdata_1, 32'h0);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk1("coll rvalid2", b_rvalid_2, 1'b1);
    chkw("coll write-first", b_rdata_2, 32'h1234_5678);
    chkw("dual rd a1", a_rdata_1, 32'h1234_5678);
    chkw("dual rd b1", b_rdata_1, 32'h1234_5678);
    tick();
    chkw("dual rd a2", a_rdata_2, 32'h1234_5678);
    chkw("dual rd b2", b_rdata_2, 32'h1234_5678);

    // Fill indices 0..7, then back-to-back reads on both ports
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b1, 32'(i * 4), expw(i), 4'hF);
      set_b(1'b1, 1'b1, 32'((i + 4) * 4), expw(i + 4), 4'hF);
      tick();
    end
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        set_a(1'b1, 1'b0, 32'(k * 4), 32'h0, 4'h0);
        set_b(1'b1, 1'b0, 32'((7 - k) * 4), 32'h0, 4'h0);
      end else begin
        set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      tick();
      chk1("burst a_rvalid1", a_rvalid_1, k < 8);
      chk1("burst a_rvalid2", a_rvalid_2, (k >= 1) && (k < 9));
      chk1("burst b_rvalid2", b_rvalid_2, (k >= 1) && (k < 9));
      if (k < 8) begin
        chkw("burst a_rdata1", a_rdata_1, expw(k));
        chkw("burst b_rdata1", b_rdata_1, expw(7 - k));
      end
      if ((k >= 1) && (k < 9)) begin
        chkw("burst a_rdata2", a_rdata_2, expw(k - 1));
        chkw("burst b_rdata2", b_rdata_2, expw(8 - k));
      end
    end

    // Out of range: read on A, write on B to index DEPTH
    set_a(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    set_b(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk1("oor ready b1", b_ready_1, 1'b1);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk1("oor rvalid1", a_rvalid_1, 1'b1);
    chk1("oor err1", a_err_1, 1'b1);
    chkw("oor rdata1", a_rdata_1, 32'h0);
    chk1("oor wr err1", b_err_1, 1'b1);
    chk1("oor wr rvalid1", b_rvalid_1, 1'b0);
    tick();
    chk1("oor err1 gone", a_err_1, 1'b0);
    chk1("oor rvalid2", a_rvalid_2, 1'b1);
    chk1("oor err2", a_err_2, 1'b1);
    chkw("oor rdata2", a_rdata_2, 32'h0);
    chk1("oor wr err2", b_err_2, 1'b1);
    chk1("oor wr rvalid2", b_rvalid_2, 1'b0);
    set_a(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chkw("oor no alias", a_rdata_1, expw(0));

    // Reset one cycle after a read accept: no late rvalid, sweep restarts
    set_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk1("flush rvalid1", a_rvalid_1, 1'b0);
    chk1("flush rvalid2", a_rvalid_2, 1'b0);
    chk1("flush busy", busy_1, 1'b1);
    seen = 1'b0;
    repeat (3) begin
      tick();
      if ((a_rvalid_1 !== 1'b0) || (a_rvalid_2 !== 1'b0)) seen = 1'b1;
    end
    chk1("flush late rvalid", seen, 1'b0);
    rst_n = 1'b1;
    wait_clear("clr2");
    set_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk1("post clr rvalid1", a_rvalid_1, 1'b1);
    chkw("post clr rdata1", a_rdata_1, 32'h0);
    tick();
    chkw("post clr rdata2", a_rdata_2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
